// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: ALU control encoding,
// RV32I opcode/funct fields and the held-output record.
package alu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_t         op;
    logic [AW-1:0]   rd;
  } issue_out_t;
endpackage

// File: rtl/alu_issue_if.sv
// Instruction-in, operands-out and write-back buses of the issue stage.
interface alu_issue_if;
  import alu_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  alu_op_t         out_alu_control;
  logic [AW-1:0]   out_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_a, out_b, out_alu_control, out_rd, illegal
  );
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_alu_control, out_rd, illegal
  );
endinterface

// File: rtl/alu_regfile.sv
// 2R1W register file, x0 tied to zero, write data bypassed to same-cycle reads.
module alu_regfile
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);
  logic [NREG-1:0][XLEN-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        mem_q <= '0;
    else if (we_i && waddr_i != '0)    mem_q[waddr_i] <= wdata_i;
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] addr);
    if (addr == '0)                 return '0;
    else if (we_i && waddr_i == addr) return wdata_i;
    else                            return mem_q[addr];
  endfunction

  assign rdata1_o = rd_port(raddr1_i);
  assign rdata2_o = rd_port(raddr2_i);
endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes the RV32I ALU subset, reads operands, stalls on the
// pending scoreboard and holds one instruction for the ALU.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic            legal, is_r, hazard, accept;
  alu_op_t         op;

  issue_out_t      out_q, out_d;
  logic            vld_q, vld_d, ill_q, ill_d;
  logic [NREG-1:0] pend_q, pend_d;

  assign opc = bus.in_instr[6:0];
  assign rd  = bus.in_instr[11:7];
  assign f3  = bus.in_instr[14:12];
  assign rs1 = bus.in_instr[19:15];
  assign rs2 = bus.in_instr[24:20];
  assign f7  = bus.in_instr[31:25];
  assign imm = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};

  always_comb begin
    legal = 1'b0;
    is_r  = 1'b0;
    op    = ADD;
    if (opc == OPC_R) begin
      is_r = 1'b1;
      unique case ({f7, f3})
        {F7_BASE, F3_ADD}: begin legal = 1'b1; op = ADD; end
        {F7_SUB,  F3_ADD}: begin legal = 1'b1; op = SUB; end
        {F7_BASE, F3_AND}: begin legal = 1'b1; op = AND; end
        {F7_BASE, F3_OR }: begin legal = 1'b1; op = OR;  end
        default: ;
      endcase
    end else if (opc == OPC_I) begin
      unique case (f3)
        F3_ADD: begin legal = 1'b1; op = ADD; end
        F3_AND: begin legal = 1'b1; op = AND; end
        F3_OR:  begin legal = 1'b1; op = OR;  end
        default: ;
      endcase
    end
  end

  // A register being written back this cycle is no longer a hazard.
  function automatic logic busy(input logic [AW-1:0] r);
    return pend_q[r] && !(bus.wb_en && bus.wb_rd == r);
  endfunction

  assign hazard = legal && (busy(rs1) || (is_r && busy(rs2)) || busy(rd));
  assign bus.in_ready = !hazard && (!vld_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

  alu_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_rd),
    .wdata_i  (bus.wb_data)
  );

  always_comb begin
    out_d  = out_q;
    vld_d  = vld_q;
    pend_d = pend_q;
    ill_d  = accept && !legal;
    if (accept && legal) begin
      out_d.a  = rdata1;
      out_d.b  = is_r ? rdata2 : imm;
      out_d.op = op;
      out_d.rd = rd;
      vld_d    = 1'b1;
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
    // Clear before set so a same-cycle issue to the same rd keeps it pending.
    if (bus.wb_en)                   pend_d[bus.wb_rd] = 1'b0;
    if (accept && legal)             pend_d[rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
      pend_q <= '0;
    end else begin
      out_q  <= out_d;
      vld_q  <= vld_d;
      ill_q  <= ill_d;
      pend_q <= pend_d;
    end
  end

  assign bus.out_valid       = vld_q;
  assign bus.out_a           = out_q.a;
  assign bus.out_b           = out_q.b;
  assign bus.out_alu_control = out_q.op;
  assign bus.out_rd          = out_q.rd;
  assign bus.illegal         = ill_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with hand-computed expected values.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_if bus();
  alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'h0;
    #2;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_illegal",   {31'b0, bus.illegal},   32'd0);
    chk("rst_out_a",     bus.out_a,              32'd0);
    chk("rst_out_b",     bus.out_b,              32'd0);
    chk("rst_ctrl",      {30'b0, bus.out_alu_control}, 32'd0);
    chk("rst_out_rd",    {27'b0, bus.out_rd},    32'd0);
    step();
    step();
    rst_n = 1'b1;

    // x1=5, x2=3
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    step();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
    step();
    bus.wb_en = 1'b0;

    // add x3,x1,x2
    bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3;
    #1 chk("add_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("add_a",     bus.out_a, 32'd5);
    chk("add_b",     bus.out_b, 32'd3);
    chk("add_ctrl",  {30'b0, bus.out_alu_control}, 32'd0);
    chk("add_rd",    {27'b0, bus.out_rd}, 32'd3);
    // add x7,x3,x0 must stall on pending x3
    bus.in_valid = 1'b1; bus.in_instr = 32'h000183B3;
    #1 chk("x3_pending_stall", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    step();

    // sub x4,x1,x2
    bus.in_valid = 1'b1; bus.in_instr = 32'h40208233;
    #1 chk("sub_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    chk("sub_a",    bus.out_a, 32'd5);
    chk("sub_b",    bus.out_b, 32'd3);
    chk("sub_ctrl", {30'b0, bus.out_alu_control}, 32'd1);
    chk("sub_rd",   {27'b0, bus.out_rd}, 32'd4);
    // addi x5,x4,-1 stalls until x4 writes back
    bus.in_instr = 32'hFFF20293;
    #1 chk("addi_stall0", {31'b0, bus.in_ready}, 32'd0);
    step();
    chk("addi_stall1", {31'b0, bus.in_ready}, 32'd0);
    chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'd2;
    #1 chk("addi_wb_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.wb_en = 1'b0; bus.in_valid = 1'b0;
    chk("addi_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("addi_a",     bus.out_a, 32'd2);
    chk("addi_b",     bus.out_b, 32'hFFFFFFFF);
    chk("addi_ctrl",  {30'b0, bus.out_alu_control}, 32'd0);
    chk("addi_rd",    {27'b0, bus.out_rd}, 32'd5);

    // backpressure: ori x6,x0,0x0F0 waits while output held
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0F006313;
    #1 chk("ori_bp_ready", {31'b0, bus.in_ready}, 32'd0);
    step();
    chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("hold_a",     bus.out_a, 32'd2);
    chk("hold_b",     bus.out_b, 32'hFFFFFFFF);
    chk("hold_rd",    {27'b0, bus.out_rd}, 32'd5);
    bus.out_ready = 1'b1;
    #1 chk("ori_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("ori_a",    bus.out_a, 32'd0);
    chk("ori_b",    bus.out_b, 32'h000000F0);
    chk("ori_ctrl", {30'b0, bus.out_alu_control}, 32'd3);
    chk("ori_rd",   {27'b0, bus.out_rd}, 32'd6);
    step();

    // add x0,x0,x0 never sets pending; wb to x0 ignored
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000033;
    step();
    chk("x0_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("x0_a",     bus.out_a, 32'd0);
    chk("x0_b",     bus.out_b, 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h0000DEAD;
    #1 chk("x0_not_pending", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.wb_en = 1'b0;
    chk("x0_bypass_a", bus.out_a, 32'd0);
    step();
    chk("x0_after_wb_a", bus.out_a, 32'd0);
    chk("x0_after_wb_b", bus.out_b, 32'd0);
    bus.in_valid = 1'b0;

    // load (rd=x3, which is pending) is illegal, dropped, no hazard
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000A183;
    #1 chk("ld_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("ld_illegal", {31'b0, bus.illegal},   32'd1);
    chk("ld_novalid", {31'b0, bus.out_valid}, 32'd0);
    step();
    chk("ld_pulse_end", {31'b0, bus.illegal}, 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h000183B3;
    #1 chk("ld_sb_unchanged", {31'b0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;

    // reset while output held and x3 pending
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h002083B3;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_a",     bus.out_a, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h000183B3;
    #1 chk("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("post_rst_a",     bus.out_a, 32'd0);
    chk("post_rst_rd",    {27'b0, bus.out_rd}, 32'd7);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
